// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared widths, op encodings and FSM states for reg_bus_master
package reg_bus_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_RMW = 2'b10, OP_RSVD = 2'b11} op_e;
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} state_e;
endpackage

// File: rtl/reg_bus_master.sv
// reg_bus_master: command-driven read/write/RMW initiator for a 16x32 register-file port
// Define REG_MASTER_RMW_EN to build read-modify-write; otherwise op 10 is rejected as reserved.
module reg_bus_master import reg_bus_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              read_en,
  output logic              write_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);
  state_e state, state_nx;
  logic live, accept, rsvd, rmw, rmw_op;
  assign accept = cmd_valid && cmd_ready;
  assign rsvd = !(cmd_op == OP_READ || cmd_op == OP_WRITE || rmw_op);
`ifdef REG_MASTER_RMW_EN
  logic [DATA_W-1:0] wdata_q, mask_q;
  assign rmw_op = cmd_op == OP_RMW;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rmw <= 1'b0;
      wdata_q <= '0;
      mask_q <= '0;
    end else if (accept) begin
      rmw <= rmw_op;
      wdata_q <= cmd_wdata;
      mask_q <= cmd_mask;
    end
`else
  logic unused_mask;
  assign unused_mask = ^cmd_mask;
  assign rmw_op = 1'b0;
  assign rmw = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = rsvd ? RESP : cmd_op == OP_WRITE ? WR_ISSUE : RD_ISSUE;
      RD_ISSUE: state_nx = RD_WAIT;
      RD_WAIT:  state_nx = rmw ? WR_ISSUE : RESP;
      WR_ISSUE: state_nx = RESP;
      RESP:     if (rsp_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  // live gates cmd_ready so it stays low through reset and rises one edge after release
  assign cmd_ready = state == IDLE && live;
  assign read_en   = state == RD_ISSUE;
  assign write_en  = state == WR_ISSUE;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      live <= 1'b0;
      addr <= '0;
      write_data <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      live <= 1'b1;
      if (accept) begin
        rsp_rdata <= '0;
        rsp_err <= rsvd;
        if (!rsvd) addr <= cmd_addr;
        if (cmd_op == OP_WRITE) write_data <= cmd_wdata;
      end
      if (state == RD_WAIT) begin
        rsp_rdata <= read_data;
`ifdef REG_MASTER_RMW_EN
        if (rmw) write_data <= (read_data & ~mask_q) | (wdata_q & mask_q);
`endif
      end
    end
endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: directed checks of reg_bus_master against a small register-file target
module tb_reg_bus_master;
  logic clk = 1'b0, rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, read_en, write_en;
  logic [1:0] cmd_op;
  logic [3:0] cmd_addr, addr;
  logic [31:0] cmd_wdata, cmd_mask, rsp_rdata, write_data, read_data;
  logic [31:0] mem [16];
  logic [31:0] exp3;
  int n_tests = 0, n_fail = 0;

  reg_bus_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .read_en(read_en),
    .write_en(write_en), .addr(addr), .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read_en) read_data <= mem[addr];
    if (write_en) mem[addr] <= write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [31:0] d, input logic [31:0] m);
    check("cmd_ready_before_issue", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_mask = m;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_strobes(input string tag, input logic re, input logic we);
    check({tag, "_read_en"}, {31'b0, read_en}, {31'b0, re});
    check({tag, "_write_en"}, {31'b0, write_en}, {31'b0, we});
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [31:0] d, input logic e);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, {31'b0, v});
    if (v) begin
      check({tag, "_rsp_rdata"}, rsp_rdata, d);
      check({tag, "_rsp_err"}, {31'b0, rsp_err}, {31'b0, e});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd0);
    check_rsp(tag, 1'b0, 32'd0, 1'b0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
    check_strobes(tag, 1'b0, 1'b0);
    check({tag, "_addr"}, {28'b0, addr}, 32'd0);
    check({tag, "_write_data"}, write_data, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    read_data = 32'd0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_addr = 4'd0;
    cmd_wdata = 32'd0;
    cmd_mask = 32'd0;
    rsp_ready = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    #1;
    check("cmd_ready_at_release", {31'b0, cmd_ready}, 32'd0);
    tick();
    check("cmd_ready_after_release", {31'b0, cmd_ready}, 32'd1);

    issue(2'b01, 4'd3, 32'h43211234, 32'd0);
    check_strobes("wr_c1", 1'b0, 1'b1);
    check("wr_c1_addr", {28'b0, addr}, 32'd3);
    check("wr_c1_write_data", write_data, 32'h43211234);
    check("wr_c1_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check_rsp("wr_c1", 1'b0, 32'd0, 1'b0);
    tick();
    check_strobes("wr_c2", 1'b0, 1'b0);
    check_rsp("wr_c2", 1'b1, 32'd0, 1'b0);
    check("wr_c2_write_data_hold", write_data, 32'h43211234);
    tick();
    check_rsp("wr_c3", 1'b0, 32'd0, 1'b0);

    issue(2'b00, 4'd3, 32'hDEADBEEF, 32'd0);
    check_strobes("rd_c1", 1'b1, 1'b0);
    check("rd_c1_addr", {28'b0, addr}, 32'd3);
    tick();
    check_strobes("rd_c2", 1'b0, 1'b0);
    check_rsp("rd_c2", 1'b0, 32'd0, 1'b0);
    tick();
    check_rsp("rd_c3", 1'b1, 32'h43211234, 1'b0);
    check("rd_c3_write_data_hold", write_data, 32'h43211234);
    tick();

    issue(2'b10, 4'd3, 32'hFFFF0000, 32'h00FF00FF);
`ifdef REG_MASTER_RMW_EN
    exp3 = 32'h43FF1200;
    check_strobes("rmw_c1", 1'b1, 1'b0);
    tick();
    check_strobes("rmw_c2", 1'b0, 1'b0);
    tick();
    check_strobes("rmw_c3", 1'b0, 1'b1);
    check("rmw_c3_write_data", write_data, 32'h43FF1200);
    check("rmw_c3_addr", {28'b0, addr}, 32'd3);
    check_rsp("rmw_c3", 1'b0, 32'd0, 1'b0);
    tick();
    check_strobes("rmw_c4", 1'b0, 1'b0);
    check_rsp("rmw_c4", 1'b1, 32'h43211234, 1'b0);
`else
    exp3 = 32'h43211234;
    check_strobes("rmw_off_c1", 1'b0, 1'b0);
    check_rsp("rmw_off_c1", 1'b1, 32'd0, 1'b1);
`endif
    tick();
    issue(2'b00, 4'd3, 32'd0, 32'd0);
    tick();
    tick();
    check_rsp("readback3", 1'b1, exp3, 1'b0);
    tick();

    issue(2'b11, 4'd15, 32'h12345678, 32'd0);
    check_strobes("rsvd_c1", 1'b0, 1'b0);
    check_rsp("rsvd_c1", 1'b1, 32'd0, 1'b1);
    check("rsvd_c1_addr_hold", {28'b0, addr}, 32'd3);
    tick();
    check_rsp("rsvd_c2", 1'b0, 32'd0, 1'b0);

    rsp_ready = 1'b0;
    issue(2'b00, 4'd3, 32'd0, 32'd0);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check_rsp("stall", 1'b1, exp3, 1'b0);
      check("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check_strobes("stall", 1'b0, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    cmd_addr = 4'd5;
    cmd_wdata = 32'hA5A5_0F0F;
    tick();
    check("post_stall_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check_rsp("post_stall", 1'b0, 32'd0, 1'b0);
    check_strobes("post_stall_idle", 1'b0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check_strobes("post_stall_wr", 1'b0, 1'b1);
    check("post_stall_addr", {28'b0, addr}, 32'd5);
    check("post_stall_write_data", write_data, 32'hA5A50F0F);
    tick();
    check_rsp("post_stall_rsp", 1'b1, 32'd0, 1'b0);
    tick();

    issue(2'b00, 4'd5, 32'd0, 32'd0);
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    #2;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      check_rsp("abort_no_rsp", 1'b0, 32'd0, 1'b0);
      check_strobes("abort_quiet", 1'b0, 1'b0);
      tick();
    end
    issue(2'b00, 4'd5, 32'd0, 32'd0);
    tick();
    tick();
    check_rsp("after_abort_read", 1'b1, 32'hA5A50F0F, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
